imem_responder: RTL

- Instruction-memory responder on the far side of the fetch stage's instruction request interface.
- Accepts one word-aligned fetch request at a time over a valid/ready handshake and returns the addressed 32-bit instruction after a fixed, parameterised latency.
- Flags misaligned and out-of-range addresses.
- Includes a write port for program preload and a flush input for branch redirects (pc_sel taken).

---
 rtl/imem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, fixed-latency reply.
// Ports: clk/reset, req valid/ready/addr, rsp valid/ready/inst/pc/err, flush, preload write.
module imem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_inst,
  output logic [31:0] o_rsp_pc,
  output logic        o_rsp_err,
  input  logic        i_rsp_ready,
  input  logic        i_flush,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] cap_addr;
  logic [31:0] rd_addr;
  logic [30:0] rd_wo, wr_wo;
  logic        rd_err, wr_ok;
  logic        load;
  logic        accept;
  logic [31:0] mem [DEPTH];

  // Bit 30 is the borrow: address below BASE_ADDR.
  function automatic logic [30:0] word_of(input logic [31:0] a);
    return 31'(({1'b0, a} - {1'b0, BASE_ADDR}) >> 2);
  endfunction

  function automatic logic bad(input logic [31:0] a, input logic [30:0] w);
    return (a[1:0] != 2'b00) || w[30] ||
           ({2'b00, w[29:0]} >= 32'(DEPTH));
  endfunction

  // With LATENCY=1 the read happens on the accept edge itself.
  assign rd_addr = (state == IDLE) ? i_req_addr : cap_addr;
  assign rd_wo   = word_of(rd_addr);
  assign rd_err  = bad(rd_addr, rd_wo);
  assign wr_wo   = word_of(i_wr_addr);
  assign wr_ok   = !bad(i_wr_addr, wr_wo);

  assign o_rsp_valid = (state == RESP);
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    load        = 1'b0;
    o_req_ready = 1'b0;
    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          o_req_ready = !reset;
          if (i_req_valid && !reset) begin
            if (LATENCY == 1) begin
              state_d = RESP;
              load    = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            load    = 1'b1;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reading mem here with <= gives old data on a same-edge preload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_addr   <= 32'd0;
      o_rsp_inst <= 32'd0;
      o_rsp_pc   <= 32'd0;
      o_rsp_err  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) cap_addr <= i_req_addr;
      if (load) begin
        o_rsp_pc   <= rd_addr;
        o_rsp_err  <= rd_err;
        o_rsp_inst <= rd_err ? NOP_INST : mem[rd_wo[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en && wr_ok) mem[wr_wo[AW-1:0]] <= i_wr_data;
  end

endmodule
